// File: rtl/seq_gen_pkg.sv
// Shared encodings for the push-button sequence generator.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package seq_gen_pkg;

  typedef logic [1:0] state_t;
  typedef logic [3:0] func_t;

  // FSM encodings; code 3 is unused and falls back to S_LFUNC.
  localparam state_t S_LFUNC = 2'd0;
  localparam state_t S_LSEED = 2'd1;
  localparam state_t S_RUN   = 2'd2;

  // ALU function codes loaded from d[3:0].
  localparam func_t FUNC_ADD = 4'b0000;
  localparam func_t FUNC_SUB = 4'b0001;
  localparam func_t FUNC_AND = 4'b0010;
  localparam func_t FUNC_OR  = 4'b0011;
  localparam func_t FUNC_XOR = 4'b0100;

endpackage

// File: rtl/alu.sv
// Combinational ALU used for each recurrence step; result wraps modulo 2^WIDTH.
// Latency: zero cycles (purely combinational).
// Backpressure: none.
module alu
  import seq_gen_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       func,
  output logic [WIDTH-1:0] y
);

  // Select the operation; undefined codes fall back to addition.
  always_comb begin
    y = a + b;
    case (func)
      FUNC_ADD: y = a + b;
      FUNC_SUB: y = a - b;
      FUNC_AND: y = a & b;
      FUNC_OR:  y = a | b;
      FUNC_XOR: y = a ^ b;
      default:  y = a + b;
    endcase
  end

endmodule

// File: rtl/btn_edge.sv
// Three-flop synchroniser on the raw button plus a one-cycle rising-edge pulse.
// Latency: en high at edge E gives pulse during the cycle after E+1.
// Backpressure: none; one pulse per rising edge of en however long it is held.
module btn_edge (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic pulse
);

  logic s1, s2, s3;

  // Flops reset to 1 so a button held through reset release never fires.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1 <= 1'b1;
      s2 <= 1'b1;
      s3 <= 1'b1;
    end else begin
      s1 <= en;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign pulse = s2 & ~s3;

endmodule

// File: rtl/seq_gen.sv
// Lagged-recurrence generator: load func, then TERMS seeds, then f(n)=f(n-TERMS) op f(n-1) per step.
// Latency: en sampled at edge E updates registers at E+2; f/n are combinational from registers.
// Backpressure: none; every pulse is consumed. Optional auto stepping under SEQ_GEN_AUTO_EN.
module seq_gen
  import seq_gen_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int TERMS  = 2,
  parameter int CNT_W  = 8
`ifdef SEQ_GEN_AUTO_EN
  ,
  parameter int PERIOD = 50_000_000
`endif
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
`ifdef SEQ_GEN_AUTO_EN
  input  logic             auto,
`endif
  output logic [WIDTH-1:0] f,
  output logic [CNT_W-1:0] n,
  output logic [1:0]       state
);

  state_t           state_q;
  func_t            func_q;
  logic [2:0]       k;
  logic [CNT_W-1:0] n_q;
  logic [WIDTH-1:0] h [TERMS];
  logic [WIDTH-1:0] y;
  logic             pulse;
  logic             step;

  btn_edge u_btn (
    .clk   (clk),
    .rst   (rst),
    .en    (en),
    .pulse (pulse)
  );

  alu #(.WIDTH(WIDTH)) u_alu (
    .a    (h[0]),
    .b    (h[TERMS-1]),
    .func (func_q),
    .y    (y)
  );

`ifdef SEQ_GEN_AUTO_EN
  localparam int PW = (PERIOD > 1) ? $clog2(PERIOD) : 1;

  logic [PW-1:0] presc;
  logic          tick;

  assign tick = (state_q == S_RUN) && auto && (presc == PW'(PERIOD - 1));

  // Prescaler runs only while auto-stepping in S_RUN; it idles at zero otherwise.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc <= '0;
    end else if ((state_q == S_RUN) && auto) begin
      presc <= tick ? '0 : presc + 1'b1;
    end else begin
      presc <= '0;
    end
  end

  // A pulse and a tick landing together still make a single step.
  assign step = pulse | tick;
`else
  assign step = pulse;
`endif

  // Load sequence and recurrence; S_RUN is left only by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_LFUNC;
      func_q  <= FUNC_ADD;
      k       <= '0;
      n_q     <= '0;
      for (int i = 0; i < TERMS; i++) h[i] <= '0;
    end else begin
      case (state_q)
        S_LFUNC: begin
          if (pulse) begin
            func_q  <= d[3:0];
            k       <= '0;
            state_q <= S_LSEED;
          end
        end
        S_LSEED: begin
          if (pulse) begin
            for (int i = 0; i < TERMS - 1; i++) h[i] <= h[i+1];
            h[TERMS-1] <= d;
            k          <= k + 1'b1;
            if (k == 3'(TERMS - 1)) state_q <= S_RUN;
          end
        end
        S_RUN: begin
          // Uses pre-edge history: no forwarding of the new term.
          if (step) begin
            for (int i = 0; i < TERMS - 1; i++) h[i] <= h[i+1];
            h[TERMS-1] <= y;
            n_q        <= n_q + 1'b1;
          end
        end
        default: state_q <= S_LFUNC;
      endcase
    end
  end

  // Display the newest term once seeding has begun; blank while loading func.
  always_comb begin
    f = '0;
    if ((state_q == S_LSEED) || (state_q == S_RUN)) f = h[TERMS-1];
  end

  assign n     = n_q;
  assign state = state_q;

endmodule

// File: tb/tb_seq_gen.sv
// Self-checking bench for seq_gen: TERMS=2 and TERMS=3 instances against a sequence-list model.
// Latency: press helper waits long enough for the E+2 update before comparing.
// Backpressure: n/a.
module tb_seq_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       en2, en3;
  logic [7:0] d;
`ifdef SEQ_GEN_AUTO_EN
  logic       auto2, auto3;
`endif
  logic [7:0] f2, f3;
  logic [7:0] n2;
  logic [2:0] n3;
  logic [1:0] st2, st3;

  int checks   = 0;
  int failures = 0;

  seq_gen #(
    .WIDTH(8), .TERMS(2), .CNT_W(8)
`ifdef SEQ_GEN_AUTO_EN
    , .PERIOD(4)
`endif
  ) dut2 (
    .clk(clk), .rst(rst), .en(en2), .d(d),
`ifdef SEQ_GEN_AUTO_EN
    .auto(auto2),
`endif
    .f(f2), .n(n2), .state(st2)
  );

  seq_gen #(
    .WIDTH(8), .TERMS(3), .CNT_W(3)
`ifdef SEQ_GEN_AUTO_EN
    , .PERIOD(4)
`endif
  ) dut3 (
    .clk(clk), .rst(rst), .en(en3), .d(d),
`ifdef SEQ_GEN_AUTO_EN
    .auto(auto3),
`endif
    .f(f3), .n(n3), .state(st3)
  );

  // Reference model: per instance (0 = TERMS 2, 1 = TERMS 3) the full list of terms so far.
  int hist [2][0:2047];
  int hlen [2];
  int mn   [2];
  int mst  [2];

  function automatic int terms_of(input int w);
    return (w == 0) ? 2 : 3;
  endfunction

  function automatic int cnt_mod(input int w);
    return (w == 0) ? 256 : 8;
  endfunction

  task automatic model_reset();
    for (int w = 0; w < 2; w++) begin
      hlen[w] = 0;
      mn[w]   = 0;
      mst[w]  = 0;
    end
  endtask

  // One press: phase 0 loads func, phase 1 appends a seed, phase 2 appends f(L-T)+f(L-1).
  task automatic model_press(input int w, input int v);
    int t;
    t = terms_of(w);
    if (mst[w] == 0) begin
      mst[w] = 1;
    end else if (mst[w] == 1) begin
      hist[w][hlen[w]] = v % 256;
      hlen[w]++;
      if (hlen[w] == t) mst[w] = 2;
    end else begin
      hist[w][hlen[w]] = (hist[w][hlen[w]-t] + hist[w][hlen[w]-1]) % 256;
      hlen[w]++;
      mn[w] = (mn[w] + 1) % cnt_mod(w);
    end
  endtask

  function automatic int model_f(input int w);
    if (mst[w] == 0 || hlen[w] == 0) return 0;
    return hist[w][hlen[w]-1];
  endfunction

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_dut(input int w, input string tag);
    if (w == 0) begin
      check({tag, " f2"}, int'(f2), model_f(0));
      check({tag, " n2"}, int'(n2), mn[0]);
      check({tag, " st2"}, int'(st2), mst[0]);
    end else begin
      check({tag, " f3"}, int'(f3), model_f(1));
      check({tag, " n3"}, int'(n3), mn[1]);
      check({tag, " st3"}, int'(st3), mst[1]);
    end
  endtask

  task automatic press(input int w, input int v, input int hold);
    @(negedge clk);
    d = 8'(v);
    if (w == 0) en2 = 1'b1;
    else        en3 = 1'b1;
    repeat (hold) @(negedge clk);
    en2 = 1'b0;
    en3 = 1'b0;
    repeat (4) @(negedge clk);
    model_press(w, v);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  typedef struct {
    int d;
    int f;
    int n;
    int st;
  } vec_t;

  vec_t tbl [8];
  int   exp3 [4];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{d: 0, f: 0,  n: 0, st: 1};
    tbl[1] = '{d: 1, f: 1,  n: 0, st: 1};
    tbl[2] = '{d: 1, f: 1,  n: 0, st: 2};
    tbl[3] = '{d: 0, f: 2,  n: 1, st: 2};
    tbl[4] = '{d: 0, f: 3,  n: 2, st: 2};
    tbl[5] = '{d: 0, f: 5,  n: 3, st: 2};
    tbl[6] = '{d: 0, f: 8,  n: 4, st: 2};
    tbl[7] = '{d: 0, f: 13, n: 5, st: 2};
    exp3[0] = 4; exp3[1] = 6; exp3[2] = 9; exp3[3] = 13;

    rst = 1'b1; en2 = 1'b0; en3 = 1'b0; d = '0;
`ifdef SEQ_GEN_AUTO_EN
    auto2 = 1'b0; auto3 = 1'b0;
`endif
    model_reset();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_dut(0, "reset");
    check_dut(1, "reset");

    // Latency: en high sampled at E, state changes at E+2 and not before.
    @(negedge clk);
    d = 8'd0; en2 = 1'b1;
    @(negedge clk); check("lat_e0", int'(st2), 0);
    @(negedge clk); check("lat_e1", int'(st2), 0);
    @(negedge clk); check("lat_e2", int'(st2), 1);
    en2 = 1'b0;
    repeat (4) @(negedge clk);

    // Fibonacci-style load and run from the table.
    do_reset();
    for (int i = 0; i < 8; i++) begin
      press(0, tbl[i].d, 1 + (i % 3));
      check($sformatf("tbl%0d f", i), int'(f2), tbl[i].f);
      check($sformatf("tbl%0d n", i), int'(n2), tbl[i].n);
      check($sformatf("tbl%0d st", i), int'(st2), tbl[i].st);
    end

    // A 1000-cycle hold is one step only.
    press(0, 0, 1000);
    check("long_hold f", int'(f2), 21);
    check("long_hold n", int'(n2), 6);

    // Modulo wrap: 200 + 100 = 300 -> 44.
    do_reset();
    press(0, 0, 1); press(0, 200, 1); press(0, 100, 2); press(0, 0, 1);
    check("wrap f", int'(f2), 44);
    check("wrap n", int'(n2), 1);

    // TERMS=3 seeds 1,2,3 then four steps, then four more to wrap the 3-bit counter.
    press(1, 0, 1); press(1, 1, 1); press(1, 2, 2); press(1, 3, 1);
    check_dut(1, "t3 seeded");
    for (int i = 0; i < 4; i++) begin
      press(1, 0, 2);
      check($sformatf("t3 step%0d f", i), int'(f3), exp3[i]);
      check($sformatf("t3 step%0d n", i), int'(n3), i + 1);
    end
    for (int i = 0; i < 4; i++) begin
      press(1, 0, 1);
      check_dut(1, $sformatf("t3 more%0d", i));
    end
    check("n_wrap", int'(n3), 0);

    // Button held through reset release must not fire.
    @(negedge clk);
    rst = 1'b1; en2 = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    model_reset();
    repeat (20) @(negedge clk);
    check("held_rst st", int'(st2), 0);
    en2 = 1'b0;
    repeat (5) @(negedge clk);
    check("held_rst low st", int'(st2), 0);
    press(0, 0, 1);
    check_dut(0, "held_rst fresh");

    // Asynchronous reset mid seed load (TERMS=3, k=1) and mid run (TERMS=2).
    do_reset();
    press(1, 0, 1); press(1, 7, 1);
    check_dut(1, "midload");
    press(0, 0, 1); press(0, 1, 1); press(0, 1, 1); press(0, 0, 1);
    check_dut(0, "midrun");
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("async f2", int'(f2), 0);
    check("async n2", int'(n2), 0);
    check("async st2", int'(st2), 0);
    check("async f3", int'(f3), 0);
    check("async st3", int'(st3), 0);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    press(0, 5, 1);
    press(1, 5, 1);
    check_dut(0, "post_rst func");
    check_dut(1, "post_rst func");

    // Randomized load and run against the model.
    for (int r = 0; r < 4; r++) begin
      do_reset();
      for (int w = 0; w < 2; w++) begin
        press(w, 0, int'($urandom_range(1, 3)));
        for (int s = 0; s < terms_of(w); s++) begin
          press(w, int'($urandom_range(0, 255)), int'($urandom_range(1, 4)));
          check_dut(w, $sformatf("rnd%0d seed%0d", r, s));
        end
        for (int s = 0; s < int'($urandom_range(5, 12)); s++) begin
          press(w, int'($urandom_range(0, 255)), int'($urandom_range(1, 6)));
          check_dut(w, $sformatf("rnd%0d step%0d", r, s));
        end
      end
    end

`ifdef SEQ_GEN_AUTO_EN
    // Auto stepping: PERIOD=4 gives one step per four cycles.
    do_reset();
    press(0, 0, 1); press(0, 1, 1); press(0, 1, 1);
    @(negedge clk);
    auto2 = 1'b1;
    repeat (8) @(negedge clk);
    auto2 = 1'b0;
    model_press(0, 0); model_press(0, 0);
    repeat (2) @(negedge clk);
    check_dut(0, "auto8");
    // Pulse and tick on the same edge: one step.
    @(negedge clk);
    auto2 = 1'b1;
    @(negedge clk);
    d = 8'd0; en2 = 1'b1;
    repeat (3) @(negedge clk);
    auto2 = 1'b0; en2 = 1'b0;
    repeat (4) @(negedge clk);
    model_press(0, 0);
    check_dut(0, "coincident");
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
